despachador_bebidas: RTL and testbench

DESPACHADOR_BEBIDAS -- requirements
Module: despachador_bebidas

---
 rtl/expendedora_pkg.sv | 26 ++
 rtl/despachador_stock.sv | 34 +++
 rtl/despachador_bebidas.sv | 117 +++++++++++
 tb/tb_despachador_bebidas.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/expendedora_pkg.sv
// Shared vending-machine definitions: dispenser state encoding, drink
// indices and the request priority resolver. Also used by the selling FSM.
package expendedora_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        GAP      = 2'd2
    } disp_state_t;

    localparam int NUM_DRINKS = 3;
    localparam int DRINK_1    = 0;
    localparam int DRINK_2    = 1;
    localparam int DRINK_3    = 2;

    // Reduce a multi-hot drink select to one-hot, lowest bit wins.
    function automatic logic [NUM_DRINKS-1:0] pick_drink(input logic [NUM_DRINKS-1:0] sel);
        logic [NUM_DRINKS-1:0] one_hot;
        one_hot = '0;
        if (sel[DRINK_1])      one_hot[DRINK_1] = 1'b1;
        else if (sel[DRINK_2]) one_hot[DRINK_2] = 1'b1;
        else if (sel[DRINK_3]) one_hot[DRINK_3] = 1'b1;
        return one_hot;
    endfunction

endpackage

// File: rtl/despachador_stock.sv
// Per-drink 4-bit stock counters with saturating decrement and reload.
// Only instantiated when DESPACHADOR_STOCK_EN is defined.
module despachador_stock
    import expendedora_pkg::*;
#(
    parameter logic [3:0] STOCK_INIT = 4'd9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DRINKS-1:0] dec,
    input  logic                  reload,
    output logic [NUM_DRINKS-1:0] empty
);

    genvar i;
    generate
        for (i = 0; i < NUM_DRINKS; i++) begin : g_drink
            logic [3:0] stock;

            // Reload takes precedence; decrement holds at zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    stock <= STOCK_INIT;
                else if (reload)
                    stock <= STOCK_INIT;
                else if (dec[i] && (stock != 4'd0))
                    stock <= stock - 4'd1;
            end

            assign empty[i] = (stock == 4'd0);
        end
    endgenerate

endmodule

// File: rtl/despachador_bebidas.sv
// Drink dispenser: accepts one request at a time, drives the selected motor
// for DISPENSE_CYCLES, then idles GAP_CYCLES before accepting again.
// Optional stock tracking is built when DESPACHADOR_STOCK_EN is defined.
module despachador_bebidas
    import expendedora_pkg::*;
#(
    parameter int         DISPENSE_CYCLES = 50_000_000,
    parameter int         GAP_CYCLES      = 25_000_000,
    parameter logic [3:0] STOCK_INIT      = 4'd9
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       req_valid,
    input  logic [2:0] req_drink,
    input  logic       restock,
    output logic       ready,
    output logic [2:0] motor,
    output logic       done,
    output logic       reject,
    output logic [2:0] empty
);

    localparam int MAX_CYCLES = (DISPENSE_CYCLES > GAP_CYCLES) ? DISPENSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    disp_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       drink;
    logic [2:0]       pick;
    logic             want;
    logic             sel_empty;
    logic             accept;

    assign pick      = pick_drink(req_drink);
    assign want      = req_valid && (req_drink != 3'b000);
    assign sel_empty = |(pick & empty);
    assign accept    = want && (state == IDLE) && !sel_empty;
    // Combinational so the pulse lines up with the offending request;
    // gated by reset so it reads 0 while btnC is held.
    assign reject    = !btnC && want && ((state != IDLE) || sel_empty);

    // Dispense sequencer; counter counts down to 0 and is reloaded, never wraps.
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            state <= IDLE;
            cnt   <= '0;
            drink <= 3'b000;
            motor <= 3'b000;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= DISPENSE;
                        cnt   <= DISP_LAST;
                        drink <= pick;
                        motor <= pick;
                        ready <= 1'b0;
                        done  <= (DISPENSE_CYCLES == 1);
                    end
                end
                DISPENSE: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GAP_LAST;
                        motor <= 3'b000;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        done <= (cnt == CNT_W'(1));
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    motor <= 3'b000;
                    ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DESPACHADOR_STOCK_EN
    logic [2:0] dec;
    logic       reload;

    // done is high during the last motor cycle, so the decrement lands as the item completes.
    assign dec    = done ? drink : 3'b000;
    assign reload = restock && (state == IDLE);

    despachador_stock #(
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk    (clk),
        .rst    (btnC),
        .dec    (dec),
        .reload (reload),
        .empty  (empty)
    );
`else
    logic unused_restock;
    assign unused_restock = restock;
    assign empty          = 3'b000;
`endif

endmodule

// File: tb/tb_despachador_bebidas.sv
// Scoreboarded bench for despachador_bebidas with DISPENSE_CYCLES=4,
// GAP_CYCLES=2, STOCK_INIT=2. Stock scenario depends on DESPACHADOR_STOCK_EN.
module tb_despachador_bebidas;

    logic       clk = 1'b0;
    logic       btnC;
    logic       req_valid;
    logic [2:0] req_drink;
    logic       restock;
    logic       ready;
    logic [2:0] motor;
    logic       done;
    logic       reject;
    logic [2:0] empty;

    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    despachador_bebidas #(
        .DISPENSE_CYCLES (4),
        .GAP_CYCLES      (2),
        .STOCK_INIT      (4'd2)
    ) dut (
        .clk       (clk),
        .btnC      (btnC),
        .req_valid (req_valid),
        .req_drink (req_drink),
        .restock   (restock),
        .ready     (ready),
        .motor     (motor),
        .done      (done),
        .reject    (reject),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each done pulse retires one expected item; motor must still show that drink.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0)
                chk("done_unexpected", 32'(1), 32'(0));
            else
                chk("done_motor", 32'(motor), 32'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full accepted item: cycle 0 request, motor 1-4, done 4, gap 5-6, ready 7.
    task automatic dispense(input logic [2:0] sel, input logic [2:0] exp_m);
        cyc();
        req_valid = 1'b1;
        req_drink = sel;
        @(negedge clk);
        chk("acc_ready", 32'(ready), 32'(1));
        chk("acc_reject", 32'(reject), 32'(0));
        exp_q.push_back(exp_m);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            req_valid = 1'b0;
            req_drink = 3'b000;
            @(negedge clk);
            chk($sformatf("motor_c%0d", c), 32'(motor), 32'((c <= 4) ? exp_m : 3'b000));
            chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 7));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 4));
        end
    endtask

    initial begin
        int d0;
        btnC      = 1'b1;
        req_valid = 1'b0;
        req_drink = 3'b000;
        restock   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_motor", 32'(motor), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_reject", 32'(reject), 32'(0));
        chk("rst_empty", 32'(empty), 32'(0));
        cyc();
        btnC = 1'b0;

        // Single dispense and priority resolution
        dispense(3'b010, 3'b010);
        dispense(3'b110, 3'b010);
        dispense(3'b111, 3'b001);

        // Zero select: ignored entirely
        cyc();
        req_valid = 1'b1;
        req_drink = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("zero_reject", 32'(reject), 32'(0));
            chk("zero_ready", 32'(ready), 32'(1));
            chk("zero_motor", 32'(motor), 32'(0));
            cyc();
        end
        req_valid = 1'b0;

        // Busy drop: requests during DISPENSE (c3) and GAP (c5) are rejected, not queued
        d0 = done_cnt;
        req_valid = 1'b1;
        req_drink = 3'b001;
        @(negedge clk);
        exp_q.push_back(3'b001);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            req_valid = (c == 3) || (c == 5);
            req_drink = req_valid ? 3'b100 : 3'b000;
            @(negedge clk);
            chk($sformatf("busy_reject_c%0d", c), 32'(reject), 32'((c == 3) || (c == 5)));
            chk($sformatf("busy_motor_c%0d", c), 32'(motor), 32'((c <= 4) ? 3'b001 : 3'b000));
            chk($sformatf("busy_ready_c%0d", c), 32'(ready), 32'(c == 7));
        end
        cyc();
        req_valid = 1'b0;
        req_drink = 3'b000;
        repeat (6) cyc();
        @(negedge clk);
        chk("busy_one_done", 32'(done_cnt - d0), 32'(1));
        chk("busy_motor_idle", 32'(motor), 32'(0));

        // Reset in the middle of a dispense
        cyc();
        req_valid = 1'b1;
        req_drink = 3'b100;
        @(negedge clk);
        exp_q.push_back(3'b100);
        cyc();
        req_valid = 1'b0;
        req_drink = 3'b000;
        cyc();
        @(negedge clk);
        chk("mid_motor_on", 32'(motor), 32'(3'b100));
        #2;
        btnC = 1'b1;
        #1;
        chk("async_motor", 32'(motor), 32'(0));
        chk("async_ready", 32'(ready), 32'(1));
        chk("async_done", 32'(done), 32'(0));
        exp_q.delete();
        #1;
        btnC = 1'b0;
        dispense(3'b010, 3'b010);

`ifdef DESPACHADOR_STOCK_EN
        // Fresh reset reloads stock to 2 per drink
        cyc();
        btnC = 1'b1;
        cyc();
        btnC = 1'b0;
        dispense(3'b001, 3'b001);
        chk("stk_empty_after1", 32'(empty), 32'(0));
        dispense(3'b001, 3'b001);
        chk("stk_empty_after2", 32'(empty), 32'(3'b001));
        cyc();
        req_valid = 1'b1;
        req_drink = 3'b001;
        @(negedge clk);
        chk("stk_reject", 32'(reject), 32'(1));
        chk("stk_ready", 32'(ready), 32'(1));
        cyc();
        req_valid = 1'b0;
        req_drink = 3'b000;
        @(negedge clk);
        chk("stk_no_motor", 32'(motor), 32'(0));
        chk("stk_still_idle", 32'(ready), 32'(1));
        cyc();
        restock = 1'b1;
        cyc();
        restock = 1'b0;
        @(negedge clk);
        chk("stk_restocked", 32'(empty), 32'(0));
        dispense(3'b001, 3'b001);
`else
        for (int n = 0; n < 5; n++) begin
            dispense(3'b100, 3'b100);
            chk($sformatf("nostk_empty_%0d", n), 32'(empty), 32'(0));
        end
`endif

        repeat (3) cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
